// File: rtl/tlc_pkg.sv
// Shared constants and types for the traffic-light input conditioner.
// Holds parameter defaults and the selector/value bus layout.
package tlc_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_HOLD_LIMIT      = 50_000_000;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned VAL_W = 4;
    localparam int unsigned BUS_W = SEL_W + VAL_W;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [VAL_W-1:0] val;
    } bus_t;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer followed by a counter-based debouncer, WIDTH bits wide.
// Multi-bit words are compared as a whole, so the stable word only ever changes atomically.
module debounce_cell
    import tlc_pkg::*;
#(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    localparam int unsigned CntW           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [CntW-1:0]  count_o
);

    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // The update fires at CntLast, so the count can never pass it and never wraps.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign count_o  = cnt_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the traffic-light controller's raw inputs into clean levels/pulses.
// Optional stuck walk-button detection is compiled in with `define STUCK_DETECT_EN.
module input_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_LIMIT      = DEF_HOLD_LIMIT
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Sensor_Raw,
    input  logic             Walk_Button,
    input  logic             Reprogram_Button,
    input  logic [SEL_W-1:0] Selector_Raw,
    input  logic [VAL_W-1:0] Value_Raw,
    output logic             Sensor,
    output logic             Walk_Request,
    output logic             Reprogram,
    output logic [SEL_W-1:0] Time_Parameter_Selector,
    output logic [VAL_W-1:0] Time_Value,
    output logic             Walk_Stuck
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

    logic             sensor_stable, walk_stable, rp_stable;
    logic [BUS_W-1:0] bus_raw, bus_stable;
    logic [CntW-1:0]  sensor_cnt, walk_cnt, rp_cnt, bus_cnt;

    assign bus_raw = {Selector_Raw, Value_Raw};

    debounce_cell #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor (
        .clk_i(clk), .rst_ni(Reset), .raw_i(Sensor_Raw),
        .stable_o(sensor_stable), .count_o(sensor_cnt)
    );

    debounce_cell #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_walk (
        .clk_i(clk), .rst_ni(Reset), .raw_i(Walk_Button),
        .stable_o(walk_stable), .count_o(walk_cnt)
    );

    debounce_cell #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reprogram (
        .clk_i(clk), .rst_ni(Reset), .raw_i(Reprogram_Button),
        .stable_o(rp_stable), .count_o(rp_cnt)
    );

    debounce_cell #(.WIDTH(BUS_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bus (
        .clk_i(clk), .rst_ni(Reset), .raw_i(bus_raw),
        .stable_o(bus_stable), .count_o(bus_cnt)
    );

    logic unused_cnt;
    assign unused_cnt = ^{sensor_cnt, walk_cnt, rp_cnt};

    logic sensor_q;
    logic walk_lvl_q, walk_lvl_d1_q, walk_req_q;
    logic rp_lvl_q, rp_lvl_d1_q, rp_q, rp_d;
    logic pending_q, pending_d;
    bus_t bus_out_q;
    logic walk_rise, rp_rise, bus_busy;

    assign walk_rise = walk_lvl_q & ~walk_lvl_d1_q;
    assign rp_rise   = rp_lvl_q & ~rp_lvl_d1_q;

    // Busy until the bus word has settled and reached the outputs, so a held
    // Reprogram pulse always lands after the new time value is visible.
    assign bus_busy = (bus_cnt != '0) || (bus_stable != bus_out_q);

    always_comb begin
        rp_d      = 1'b0;
        pending_d = pending_q;
        if (!bus_busy) begin
            rp_d      = pending_q | rp_rise;
            pending_d = 1'b0;
        end else if (rp_rise) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sensor_q      <= 1'b0;
            walk_lvl_q    <= 1'b0;
            walk_lvl_d1_q <= 1'b0;
            walk_req_q    <= 1'b0;
            rp_lvl_q      <= 1'b0;
            rp_lvl_d1_q   <= 1'b0;
            rp_q          <= 1'b0;
            pending_q     <= 1'b0;
            bus_out_q     <= '0;
        end else begin
            sensor_q      <= sensor_stable;
            walk_lvl_q    <= walk_stable;
            walk_lvl_d1_q <= walk_lvl_q;
            walk_req_q    <= walk_rise;
            rp_lvl_q      <= rp_stable;
            rp_lvl_d1_q   <= rp_lvl_q;
            rp_q          <= rp_d;
            pending_q     <= pending_d;
            bus_out_q     <= bus_stable;
        end
    end

    assign Sensor                  = sensor_q;
    assign Walk_Request            = walk_req_q;
    assign Reprogram               = rp_q;
    assign Time_Parameter_Selector = bus_out_q.sel;
    assign Time_Value              = bus_out_q.val;

`ifdef STUCK_DETECT_EN
    localparam int unsigned HoldW = $clog2(HOLD_LIMIT + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_LIMIT);

    logic [HoldW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = '0;
        if (walk_lvl_q) begin
            hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HoldW'(1);
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign Walk_Stuck = walk_lvl_q && (hold_q == HoldMax);
`else
    logic unused_hold_limit;
    assign unused_hold_limit = ^HOLD_LIMIT;
    assign Walk_Stuck        = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4, HOLD_LIMIT=20.
module tb_input_conditioner;

    localparam int unsigned DC = 4;
    localparam int unsigned HL = 20;
`ifdef STUCK_DETECT_EN
    localparam bit StuckEn = 1'b1;
`else
    localparam bit StuckEn = 1'b0;
`endif

    logic       clk;
    logic       Reset;
    logic       Sensor_Raw, Walk_Button, Reprogram_Button;
    logic [1:0] Selector_Raw;
    logic [3:0] Value_Raw;
    logic       Sensor, Walk_Request, Reprogram, Walk_Stuck;
    logic [1:0] Time_Parameter_Selector;
    logic [3:0] Time_Value;

    int passed = 0;
    int total  = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(DC), .HOLD_LIMIT(HL)) dut (
        .clk                     (clk),
        .Reset                   (Reset),
        .Sensor_Raw              (Sensor_Raw),
        .Walk_Button             (Walk_Button),
        .Reprogram_Button        (Reprogram_Button),
        .Selector_Raw            (Selector_Raw),
        .Value_Raw               (Value_Raw),
        .Sensor                  (Sensor),
        .Walk_Request            (Walk_Request),
        .Reprogram               (Reprogram),
        .Time_Parameter_Selector (Time_Parameter_Selector),
        .Time_Value              (Time_Value),
        .Walk_Stuck              (Walk_Stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call ends 1 ns after a rising edge; the next edge is the one that samples new drives.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Sensor_Raw = 0; Walk_Button = 0; Reprogram_Button = 0;
        Selector_Raw = '0; Value_Raw = '0;
        #2;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) Reset = 1'b1;
            tick();
            total++;
            if ({Sensor, Walk_Request, Reprogram, Time_Parameter_Selector, Time_Value,
                 Walk_Stuck} !== 10'b0)
                $display("FAIL reset k=%0d outputs=%b required 0", k,
                         {Sensor, Walk_Request, Reprogram, Time_Parameter_Selector,
                          Time_Value, Walk_Stuck});
            else passed++;
        end
    endtask

    task automatic test_sensor_latency();
        Sensor_Raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (Sensor !== (k >= 6))
                $display("FAIL sensor_latency k=%0d got %b required %b", k, Sensor, k >= 6);
            else passed++;
        end
    endtask

    task automatic test_sensor_glitch();
        Sensor_Raw = 1'b0;
        repeat (12) tick();
        Sensor_Raw = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (Sensor !== 1'b0)
                $display("FAIL sensor_glitch3 k=%0d got %b required 0", k, Sensor);
            else passed++;
            if (k == 2) Sensor_Raw = 1'b0;
        end
        // Exactly DEBOUNCE_CYCLES long: just enough to be accepted, then released.
        Sensor_Raw = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (Sensor !== (k >= 6 && k < 10))
                $display("FAIL sensor_pulse4 k=%0d got %b required %b", k, Sensor,
                         (k >= 6 && k < 10));
            else passed++;
            if (k == 3) Sensor_Raw = 1'b0;
        end
    endtask

    task automatic test_walk_hold();
        int pulses = 0;
        Walk_Button = 1'b1;
        for (int k = 0; k < 120; k++) begin
            tick();
            total++;
            if (Walk_Request !== (k == 7))
                $display("FAIL walk_pulse k=%0d got %b required %b", k, Walk_Request, k == 7);
            else passed++;
            total++;
            if (Walk_Stuck !== (StuckEn && k >= 26 && k < 106))
                $display("FAIL walk_stuck k=%0d got %b required %b", k, Walk_Stuck,
                         (StuckEn && k >= 26 && k < 106));
            else passed++;
            if (Walk_Request === 1'b1) pulses++;
            if (k == 99) Walk_Button = 1'b0;
        end
        total++;
        if (pulses != 1) $display("FAIL walk_pulse_count got %0d required 1", pulses);
        else passed++;
    endtask

    task automatic test_simultaneous();
        Walk_Button = 1'b1;
        Reprogram_Button = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if ({Walk_Request, Reprogram} !== {2{k == 7}})
                $display("FAIL simultaneous k=%0d got %b required %b", k,
                         {Walk_Request, Reprogram}, {2{k == 7}});
            else passed++;
        end
        Walk_Button = 1'b0;
        Reprogram_Button = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reprogram_after_bus();
        Value_Raw = 4'h3;
        repeat (12) tick();
        Value_Raw = 4'h9;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (Time_Value !== ((k >= 6) ? 4'h9 : 4'h3))
                $display("FAIL bus_value k=%0d got %h required %h", k, Time_Value,
                         (k >= 6) ? 4'h9 : 4'h3);
            else passed++;
            total++;
            if (Reprogram !== (k == 8))
                $display("FAIL reprog_after_bus k=%0d got %b required %b", k, Reprogram, k == 8);
            else passed++;
            if (k == 0) Reprogram_Button = 1'b1;
        end
        Reprogram_Button = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reprogram_pending();
        Reprogram_Button = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (Time_Value !== ((k >= 9) ? 4'hC : 4'h9))
                $display("FAIL pending_value k=%0d got %h required %h", k, Time_Value,
                         (k >= 9) ? 4'hC : 4'h9);
            else passed++;
            total++;
            if (Reprogram !== (k == 10))
                $display("FAIL reprog_pending k=%0d got %b required %b", k, Reprogram, k == 10);
            else passed++;
            if (k == 2) Value_Raw = 4'hC;
        end
        Reprogram_Button = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reprogram_cancel();
        Reprogram_Button = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (Time_Value !== 4'hC)
                $display("FAIL cancel_value k=%0d got %h required c", k, Time_Value);
            else passed++;
            total++;
            if (Reprogram !== (k == 8))
                $display("FAIL reprog_cancel k=%0d got %b required %b", k, Reprogram, k == 8);
            else passed++;
            if (k == 2) Value_Raw = 4'h6;
            if (k == 4) Value_Raw = 4'hC;
        end
        Reprogram_Button = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_bus_atomic();
        logic [5:0] old_w, new_w, exp_w;
        old_w = 6'b00_0101;
        new_w = 6'b11_1010;
        {Selector_Raw, Value_Raw} = old_w;
        repeat (12) tick();
        {Selector_Raw, Value_Raw} = new_w;
        for (int k = 0; k < 36; k++) begin
            int nxt;
            tick();
            exp_w = (k >= 26) ? new_w : old_w;
            total++;
            if ({Time_Parameter_Selector, Time_Value} !== exp_w)
                $display("FAIL bus_atomic k=%0d got %b required %b", k,
                         {Time_Parameter_Selector, Time_Value}, exp_w);
            else passed++;
            nxt = k + 1;
            if (nxt < 20 && ((nxt / 2) % 2) == 1) {Selector_Raw, Value_Raw} = old_w;
            else {Selector_Raw, Value_Raw} = new_w;
        end
    endtask

    task automatic test_reset_mid_debounce();
        Walk_Button = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (Walk_Request !== 1'b0)
                $display("FAIL pre_reset_pulse k=%0d got %b required 0", k, Walk_Request);
            else passed++;
        end
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) #1;
            else tick();
            total++;
            if ({Sensor, Walk_Request, Reprogram, Time_Parameter_Selector, Time_Value,
                 Walk_Stuck} !== 10'b0)
                $display("FAIL mid_reset k=%0d outputs=%b required 0", k,
                         {Sensor, Walk_Request, Reprogram, Time_Parameter_Selector,
                          Time_Value, Walk_Stuck});
            else passed++;
        end
        Reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (Walk_Request !== (k == 7))
                $display("FAIL post_reset_pulse k=%0d got %b required %b", k, Walk_Request,
                         k == 7);
            else passed++;
        end
        Walk_Button = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        test_reset();
        test_sensor_latency();
        test_sensor_glitch();
        test_walk_hold();
        test_simultaneous();
        test_reprogram_after_bus();
        test_reprogram_pending();
        test_reprogram_cancel();
        test_bus_atomic();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive cycles a synchronized input must hold a new value before it is accepted; legal range 2..65535.
REQ-002 Parameter HOLD_LIMIT, default 50000000, cycles a debounced walk press may stay asserted before it is flagged stuck; used only under REQ-026.
REQ-003 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-005 Sensor_Raw  in  1  unsynchronized vehicle-sensor contact.
REQ-006 Walk_Button  in  1  unsynchronized pedestrian push-button, high while pressed.
REQ-007 Reprogram_Button  in  1  unsynchronized reprogram push-button, high while pressed.
REQ-008 Selector_Raw  in  2  unsynchronized time-parameter selector switches.
REQ-009 Value_Raw  in  4  unsynchronized time-value switches.
REQ-010 Sensor  out  1  debounced sensor level.
REQ-011 Walk_Request  out  1  one-cycle pulse per debounced walk press.
REQ-012 Reprogram  out  1  one-cycle pulse per debounced reprogram press.
REQ-013 Time_Parameter_Selector  out  2  debounced selector, updated atomically with Time_Value.
REQ-014 Time_Value  out  4  debounced time value.
REQ-015 Walk_Stuck  out  1  stuck-button flag; tied 0 when REQ-026 is not compiled in.

Function
REQ-016 Each 1-bit input SHALL pass through a two-flop synchronizer before any other logic.
REQ-017 Each 1-bit channel SHALL hold a stable register and a counter; the counter increments on every edge where the synchronized value differs from stable and clears on any edge where they match.
REQ-018 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, stable SHALL take the synchronized value and the counter SHALL clear on that same edge.
REQ-019 Latency: a clean raw transition SHALL appear on Sensor exactly DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples it.
REQ-020 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-021 Walk_Request and Reprogram SHALL be registered rising-edge detects of their stable registers. Each is high for exactly one cycle, DEBOUNCE_CYCLES+3 cycles after the raw press, regardless of how long the button is held. Releasing the button SHALL produce no pulse.
REQ-022 The 6-bit bus {Selector_Raw, Value_Raw} SHALL be debounced as one word, with one two-flop synchronizer per bit, one counter, and a whole-word compare. The two bus outputs SHALL update together on the same edge and SHALL never show a mix of old and new bits.
REQ-023 If the Reprogram edge occurs while the bus counter is non-zero, the pulse SHALL be held pending. The pending pulse SHALL be emitted on the cycle after the bus outputs update, or on the cycle after the bus counter returns to 0 without an update. At most one pulse SHALL be pending; further Reprogram edges while pending SHALL be dropped.
REQ-024 Counters SHALL saturate and never wrap. Counter width SHALL be $clog2(DEBOUNCE_CYCLES).
REQ-025 Simultaneous walk and reprogram edges SHALL each produce their own pulse independently, in the same cycle when nothing is pending.

Configuration
REQ-026 When STUCK_DETECT_EN is defined, a hold counter SHALL count cycles while walk stable is 1. Walk_Stuck SHALL assert when the count reaches HOLD_LIMIT and SHALL clear on the edge walk stable returns to 0. Without the macro, the counter SHALL be absent and Walk_Stuck SHALL be constant 0.

Reset
REQ-027 While Reset is 0, all of the following SHALL be 0: synchronizer flops, stable registers, counters, the pending flag, and every output.
REQ-028 Reset asserted in the middle of a debounce or a pending pulse SHALL discard it. After release, an input already high SHALL be accepted as a new transition: level outputs after REQ-019 latency, and one press pulse.

Structure
REQ-029 Package tlc_pkg SHALL hold the DEBOUNCE_CYCLES and HOLD_LIMIT defaults and the bus-width constants SEL_W=2 and VAL_W=4.
REQ-030 Sub-module debounce_cell, parameterized by width, SHALL implement REQ-016..018. It SHALL be instantiated four times: sensor, walk, reprogram, and the 6-bit bus.

Verification (DEBOUNCE_CYCLES=4, HOLD_LIMIT=20)
REQ-031 Sensor_Raw 0->1 held -> Sensor rises 6 cycles later; 3-cycle Sensor_Raw glitch -> Sensor stays 0.
REQ-032 Walk_Button held 100 cycles -> exactly one Walk_Request pulse at cycle 7, no pulse on release.
REQ-033 Value_Raw 0x3->0x9 with Reprogram_Button pressed 1 cycle later -> Time_Value=0x9 strictly before the single Reprogram pulse.
REQ-034 Selector_Raw and Value_Raw changing every 2 cycles for 20 cycles then held -> outputs never change during toggling, then both update on one edge.
REQ-035 Reset pulsed low at count 2 of a walk debounce, button still high -> no pulse before reset; one pulse 7 cycles after release.
REQ-036 With STUCK_DETECT_EN, walk held 40 cycles -> Walk_Stuck=1 from debounced+20 cycles until release; without the macro -> Walk_Stuck always 0.
